// File: rtl/sti_pattern_loader.sv
// Feeds buffered host words to the STI_DAC transmitter one at a time. Each
// word is issued with a one-cycle load strobe and the next word waits until
// the transmitter's so_valid burst has ended, been length-checked and counted.
module sti_pattern_loader #(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_cfg,
  input  logic        in_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        busy,
  output logic [7:0]  word_count,
  output logic        err_timeout,
  output logic        err_len
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [21:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [21:0]   head;
  logic          push, pop;
  logic          last_seen;
  logic [5:0]    bit_cnt;
  logic [3:0]    tmo_cnt;

  // Bit counter increment that sticks at 63 so overlong bursts never alias
  // back onto a legal length.
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  // Expected burst length in bits for a length code: 8, 16, 24 or 32.
  function automatic logic [5:0] burst_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rd_ptr];
  // Not pop-aware on purpose: a full FIFO refuses a push even while popping.
  assign in_ready   = !fifo_full && !last_seen;
  assign push       = in_valid && in_ready;
  assign load       = (state == S_LOAD);
  assign busy       = !fifo_empty || ((state != S_IDLE) && (state != S_DONE));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; pop is raised wherever a new word is taken from the FIFO.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (so_valid)                               state_nxt = S_WAIT_DONE;
        else if (tmo_cnt == 4'(START_TIMEOUT))      state_nxt = S_GAP;
      end
      S_WAIT_DONE: begin
        if (!so_valid) state_nxt = S_GAP;
      end
      S_GAP: begin
        // pi_end is set only by the final word, so it marks the current word as last.
        if (pi_end)           state_nxt = S_DONE;
        else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end else              state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; entries are {last, cfg, data}.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_last, in_cfg, in_data};
  end

  // FIFO pointers, occupancy and the frame-closed latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      last_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
      if (push && in_last) last_seen <= 1'b1;
    end
  end

  // Transmit fields are captured on the pop edge and held until the next pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pi_data   <= '0;
      pi_length <= '0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      pi_end    <= 1'b0;
    end else if (pop) begin
      pi_data                              <= head[15:0];
      {pi_length, pi_fill, pi_msb, pi_low} <= head[20:16];
      if (head[21]) pi_end <= 1'b1;
    end
  end

  // Burst measurement, start timeout, completed-word count and sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      word_count  <= '0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
        S_WAIT_START: begin
          if (so_valid)                          bit_cnt     <= 6'd1;
          else if (tmo_cnt == 4'(START_TIMEOUT)) err_timeout <= 1'b1;
          else                                   tmo_cnt     <= tmo_cnt + 4'd1;
        end
        S_WAIT_DONE: begin
          if (so_valid) bit_cnt <= sat_inc6(bit_cnt);
          else begin
            if (bit_cnt != burst_bits(pi_length)) err_len <= 1'b1;
            word_count <= word_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
